// File: rtl/rv32i_rob_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rv32i_pkg / rv32i_rob_wb_arbiter
//
// Purpose:
//   Arbitrates NUM_PU processing-unit write-back requests onto the single ROB
//   write-back port. One request is accepted per cycle. The accepted index and
//   exception flag are presented to the ROB one cycle later from registers.
//   A ROB flush accepts and discards every pending request. The default build
//   uses round-robin priority. Defining RV32I_WB_ARB_FIXED_PRIO_EN selects
//   fixed lowest-index-first priority and ties the pointer to 0.
//
// Ports:
//   clk                        rising-edge clock
//   rstn                       asynchronous active-low reset
//   i_pu_wb_vld[NUM_PU]        per-PU write-back request
//   i_pu_wb_rob_idx[NUM_PU]    per-PU ROB entry index (ROB_IDX_BW each)
//   i_pu_wb_except[NUM_PU]     per-PU exception flag
//   i_rob_flush                ROB flush: accept and drop all requests
//   o_pu_wb_rdy[NUM_PU]        per-PU accept (combinational)
//   o_write_back               registered write-back strobe to the ROB
//   o_write_back_rob_entry_idx registered ROB index of the write-back
//   o_write_back_except_vld    registered exception flag of the write-back
//   o_grant_ptr                round-robin priority pointer (debug)
// -----------------------------------------------------------------------------

package rv32i_pkg;
    parameter int unsigned ROB_DEPTH = 32;
endpackage

module rv32i_rob_wb_arbiter #(
    parameter int unsigned NUM_PU     = 4,
    parameter int unsigned ROB_IDX_BW = $clog2(rv32i_pkg::ROB_DEPTH)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_PU-1:0]                   i_pu_wb_vld,
    input  logic [NUM_PU-1:0][ROB_IDX_BW-1:0]   i_pu_wb_rob_idx,
    input  logic [NUM_PU-1:0]                   i_pu_wb_except,
    input  logic                                i_rob_flush,
    output logic [NUM_PU-1:0]                   o_pu_wb_rdy,
    output logic                                o_write_back,
    output logic [ROB_IDX_BW-1:0]               o_write_back_rob_entry_idx,
    output logic                                o_write_back_except_vld,
    output logic [$clog2(NUM_PU)-1:0]           o_grant_ptr
);

    localparam int unsigned PTR_BW = $clog2(NUM_PU);

    logic [PTR_BW-1:0]     start_ptr;
    logic                  gnt_vld;
    logic [PTR_BW-1:0]     gnt_idx;

    logic                  wb_q,  wb_d;
    logic [ROB_IDX_BW-1:0] idx_q, idx_d;
    logic                  exc_q, exc_d;

    // Search the requesters starting at start_ptr and wrapping modulo NUM_PU.
    // The candidate never exceeds 2*NUM_PU-2, so one conditional subtraction
    // replaces a modulo and keeps non-power-of-two NUM_PU correct.
    always_comb begin
        int unsigned cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_PU; i++) begin
            cand = 32'(start_ptr) + i;
            if (cand >= NUM_PU) begin
                cand = cand - NUM_PU;
            end
            if (!gnt_vld && i_pu_wb_vld[PTR_BW'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_BW'(cand);
            end
        end
    end

    // Accept: nothing in reset, everything pending during a flush,
    // otherwise the single arbitration winner.
    always_comb begin
        o_pu_wb_rdy = '0;
        if (!rstn) begin
            o_pu_wb_rdy = '0;
        end else if (i_rob_flush) begin
            o_pu_wb_rdy = i_pu_wb_vld;
        end else if (gnt_vld) begin
            o_pu_wb_rdy[gnt_idx] = 1'b1;
        end
    end

    // Flushed transfers are consumed but never reach the ROB; the index and
    // exception registers only load on a real write-back and hold otherwise.
    always_comb begin
        wb_d  = gnt_vld & ~i_rob_flush;
        idx_d = idx_q;
        exc_d = exc_q;
        if (wb_d) begin
            idx_d = i_pu_wb_rob_idx[gnt_idx];
            exc_d = i_pu_wb_except[gnt_idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_q  <= 1'b0;
            idx_q <= '0;
            exc_q <= 1'b0;
        end else begin
            wb_q  <= wb_d;
            idx_q <= idx_d;
            exc_q <= exc_d;
        end
    end

`ifdef RV32I_WB_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always starts at PU0.
    assign start_ptr = '0;
`else
    logic [PTR_BW-1:0] ptr_q, ptr_d;

    // Pointer moves just past the PU that actually wrote back; it holds on
    // idle cycles and during a flush.
    always_comb begin
        ptr_d = ptr_q;
        if (wb_d) begin
            ptr_d = (gnt_idx == PTR_BW'(NUM_PU - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign start_ptr = ptr_q;
`endif

    assign o_grant_ptr                = start_ptr;
    assign o_write_back               = wb_q;
    assign o_write_back_rob_entry_idx = idx_q;
    assign o_write_back_except_vld    = exc_q;

endmodule

// File: doc/rv32i_rob_wb_arbiter.md
RV32I_ROB_WB_ARBITER -- requirements
Module: rv32i_rob_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_PU, default 4, meaning the number of processing units sharing the ROB write-back port (legal range 2..8).
REQ-002 SHALL have parameter ROB_IDX_BW, default $clog2(ROB_DEPTH) from rv32i_pkg, meaning the width of a ROB entry index.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all flops are on its rising edge.
REQ-004 SHALL have port rstn, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port i_pu_wb_vld, input, NUM_PU, meaning a per-PU write-back request.
REQ-006 SHALL have port i_pu_wb_rob_idx, input, NUM_PU x ROB_IDX_BW, meaning the per-PU ROB entry index being completed.
REQ-007 SHALL have port i_pu_wb_except, input, NUM_PU, meaning the per-PU exception flag.
REQ-008 SHALL have port i_rob_flush, input, 1, meaning the ROB flush indication.
REQ-009 SHALL have port o_pu_wb_rdy, output, NUM_PU, meaning a per-PU grant/accept.
REQ-010 SHALL have port o_write_back, output, 1, meaning the write-back strobe to the ROB.
REQ-011 SHALL have port o_write_back_rob_entry_idx, output, ROB_IDX_BW, meaning the ROB index of that write-back.
REQ-012 SHALL have port o_write_back_except_vld, output, 1, meaning the exception flag of that write-back.
REQ-013 SHALL have port o_grant_ptr, output, $clog2(NUM_PU), meaning the current round-robin priority pointer, for debug.

Function
REQ-014 Handshake: a transfer on PU k SHALL occur in a cycle where i_pu_wb_vld[k] and o_pu_wb_rdy[k] are both 1; the PU SHALL hold vld, idx and except stable until then.
REQ-015 o_pu_wb_rdy SHALL be combinational from i_pu_wb_vld, the pointer and i_rob_flush, and SHALL be one-hot or zero while i_rob_flush=0.
REQ-016 Round-robin: among the requesting PUs, the grant SHALL go to the first index at or after o_grant_ptr, wrapping modulo NUM_PU.
REQ-017 After a grant to PU k, o_grant_ptr SHALL become (k+1) mod NUM_PU on the next edge; with no grant it SHALL hold.
REQ-018 Latency: a transfer in cycle T SHALL drive o_write_back=1 with the matching idx and except in cycle T+1, from registered outputs only.
REQ-019 With no transfer in cycle T, o_write_back SHALL be 0 in T+1; idx and except SHALL hold their last values.
REQ-020 Throughput: one write-back per cycle; back-to-back grants to different PUs SHALL produce consecutive o_write_back pulses.
REQ-021 A single requester asserting vld continuously SHALL be granted every cycle.
REQ-022 Flush: while i_rob_flush=1, o_pu_wb_rdy SHALL equal i_pu_wb_vld (all pending requests accepted and discarded); o_write_back SHALL be 0 in the following cycle; the pointer SHALL hold.
REQ-023 A write-back registered in cycle T SHALL still be presented in T+1 even if i_rob_flush rises in T+1.
REQ-024 Fairness: with all NUM_PU requesting continuously, each PU SHALL be granted exactly once per NUM_PU cycles.

Reset
REQ-025 On rstn=0, asynchronously: o_write_back=0, o_write_back_rob_entry_idx=0, o_write_back_except_vld=0, o_grant_ptr=0.
REQ-026 While in reset, o_pu_wb_rdy SHALL be all 0; reset asserted mid-transfer SHALL drop that transfer, and no pulse SHALL follow reset release.

Configuration
REQ-027 Macro RV32I_WB_ARB_FIXED_PRIO_EN defined: the grant SHALL always go to the lowest requesting index, and o_grant_ptr SHALL be tied to 0.
REQ-028 Macro undefined: round-robin per REQ-016/017; all other requirements SHALL be identical in both builds.

Verification
REQ-029 NUM_PU=4; PU2 vld with idx=5, except=0 for one cycle T -> rdy[2]=1 in T; T+1: o_write_back=1, idx=5, except=0; ptr=3.
REQ-030 All 4 PUs vld continuously from ptr=0 -> grant order 0,1,2,3,0; five consecutive o_write_back pulses.
REQ-031 PU1 and PU3 vld with ptr=2 -> PU3 granted first, then PU1; ptr goes 0 then 2.
REQ-032 PU0 idx=9, except=1 granted -> next cycle o_write_back_except_vld=1, idx=9.
REQ-033 i_rob_flush=1 with PU0 and PU1 vld -> rdy=4'b0011, o_write_back=0 next cycle, ptr unchanged.
REQ-034 rstn pulled low mid-stream with PU1 granted -> outputs 0 immediately; after release, no write-back without a new request.
